uparc_fetch: RTL and testbench
==============================

// Module: uparc_fetch
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the decode stage.
//  Owns the PC and issues single-word reads on the instruction bus.
//  Holds each fetched word for decode until the core advances, and applies jump and exception redirects.
//  Drives the fetch stall into the CU stall network.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  PC loaded on reset (first fetch address)
// PORTS
//  clk             in   1   clock, rising edge
//  nrst            in   1   asynchronous active-low reset
//  i_exec_stall    in   1   exec stage stall
//  i_mem_stall     in   1   memory stage stall
//  i_wait_stall    in   1   WAIT stall
//  o_fetch_stall   out  1   1 = no valid instruction held for decode
//  i_jump_valid    in   1   1-cycle pulse: redirect to i_jump_addr
//  i_jump_addr     in   32  jump/branch target
//  i_except_start  in   1   1-cycle pulse: redirect to i_except_vect
//  i_except_vect   in   32  exception vector address
//  o_instr         out  32  instruction word presented to decode
//  o_pc            out  32  PC of o_instr
//  o_bus_error     out  1   1-cycle pulse: bus error on fetch
//  o_addr_error    out  1   1-cycle pulse: misaligned PC (see CONFIGURATION)
//  o_ibus_addr     out  32  instruction bus address
//  o_ibus_rd       out  1   read request, held until i_ibus_rdc
//  i_ibus_rdc      in   1   read complete; data/err valid this cycle
//  i_ibus_data     in   32  read data
//  i_ibus_err      in   1   bus error, qualified by i_ibus_rdc
// BEHAVIOUR
//  Reset values
//   pc = RESET_PC, o_pc = RESET_PC, o_instr = NOP (32'h0), state = FETCH.
//   o_ibus_rd = 0, o_fetch_stall = 1, errors = 0.
//   pend_jmp = 0, discard = 0.
//  FSM {FETCH, WAIT, HOLD}; other_stall = exec|mem|wait stall.
//   FETCH: drive o_ibus_rd=1, o_ibus_addr=pc; go to WAIT.
//   WAIT: hold rd/addr stable until i_ibus_rdc.
//    On rdc with discard=0:
//     o_instr <= err ? NOP : i_ibus_data; o_pc <= pc.
//     o_bus_error <= err; o_ibus_rd <= 0; go to HOLD.
//   HOLD: o_fetch_stall=0.
//    When !other_stall, decode samples o_instr this cycle.
//    pc <= next_pc; go to FETCH.
//  o_fetch_stall = (state != HOLD), registered-state decode, no comb path from bus.
//  Timing
//   Min latency: request to HOLD = 2 cycles with a zero-wait bus.
//   Throughput: 1 instr / 3 cycles.
//  next_pc priority: except > pending jump > pc+4 (32-bit wrap, no flag).
//  i_jump_valid: latch i_jump_addr into pend_jmp in any state.
//   Consumed at the next HOLD->FETCH advance.
//   A second jump before consumption overwrites the first.
//  i_except_start
//   In HOLD or FETCH: pc <= i_except_vect; pend_jmp cleared; o_instr <= NOP.
//    State goes to FETCH next cycle.
//   In WAIT: set discard and pc <= i_except_vect; pend_jmp cleared.
//    The outstanding read is never aborted.
//    On its rdc the data and err are dropped and state goes to FETCH.
//   Same-cycle jump+except: the exception wins and the jump is lost.
//  Same-cycle rdc+except in WAIT: the data is discarded.
//  Error pulses last exactly 1 cycle; the CU converts them to exceptions.
//  Async reset mid-transaction: all state is reset immediately and rd drops.
//   The bus must tolerate an abandoned request.
// CONFIGURATION
//  UPARC_FETCH_ALIGN_CHECK_EN defined
//   In FETCH, pc[1:0]!=0 issues no bus read.
//   o_addr_error pulses; o_instr=NOP, o_pc=pc; go to HOLD.
//  UPARC_FETCH_ALIGN_CHECK_EN undefined
//   o_ibus_addr[1:0] forced to 2'b00; o_addr_error tied 0.
// STRUCTURE
//  Shared include uparc_cpu_const.vh: NOP word, fetch FSM state encodings.
//  UPARC_ADDR_WIDTH / UPARC_INSTR_WIDTH come from uparc_cpu_common.vh.
//  One sub-module, uparc_fetch_pcsel: next_pc priority mux, pend_jmp register, pc+4 adder.
//  FSM and bus handshake stay in uparc_fetch.
// TESTING
//  Reset, zero-wait bus, no stalls:
//   rd at RESET_PC, then 0xBFC00004, 0xBFC00008, every 3 cycles.
//   o_fetch_stall low 1 cycle per word.
//  rdc delayed 5 cycles:
//   addr/rd stable throughout; o_fetch_stall high until the cycle after rdc.
//  HOLD with i_mem_stall=1 for 4 cycles:
//   o_instr/o_pc unchanged; no new rd until the stall drops.
//  Jump pulse to 0x00001000 during WAIT of 0xBFC00004:
//   0xBFC00004 is delivered; the next fetch is at 0x00001000.
//  i_except_start (vect 0x80000180) during WAIT:
//   old data discarded; next rd at 0x80000180; no o_bus_error.
//  rdc with i_ibus_err=1:
//   o_bus_error pulses once; o_instr=NOP.
//  With ALIGN_CHECK_EN, jump to 0x1002:
//   o_addr_error pulses once; no rd issued.

Source files
------------

// File: rtl/uparc_fetch_pkg.sv
// uparc_fetch_pkg: shared widths, NOP word and fetch FSM state encodings
//   UPARC_ADDR_WIDTH / UPARC_INSTR_WIDTH : bus address / instruction widths
//   UPARC_NOP                            : word handed to decode when nothing real is held
//   fetch_state_t                        : FETCH (issue read), WAIT (read in flight), HOLD (word held for decode)
package uparc_fetch_pkg;
  localparam int UPARC_ADDR_WIDTH = 32;
  localparam int UPARC_INSTR_WIDTH = 32;
  localparam logic [UPARC_INSTR_WIDTH-1:0] UPARC_NOP = '0;
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/uparc_fetch_pcsel.sv
// uparc_fetch_pcsel: next-PC selection for the fetch stage
//   clk, nrst     : clock, asynchronous active-low reset
//   pc            : current fetch PC
//   jump_valid    : jump pulse, jump_addr is latched as a pending redirect
//   except_start  : exception pulse, wins over everything and drops any pending jump
//   except_vect   : exception vector
//   advance       : decode took the held word this cycle
//   next_pc       : except_vect > pending jump > pc+4 (wraps silently)
//   pc_load       : pc must take next_pc this cycle
module uparc_fetch_pcsel
  import uparc_fetch_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [UPARC_ADDR_WIDTH-1:0] pc,
  input  logic                        jump_valid,
  input  logic [UPARC_ADDR_WIDTH-1:0] jump_addr,
  input  logic                        except_start,
  input  logic [UPARC_ADDR_WIDTH-1:0] except_vect,
  input  logic                        advance,
  output logic [UPARC_ADDR_WIDTH-1:0] next_pc,
  output logic                        pc_load
);
  logic                        pend_vld;
  logic [UPARC_ADDR_WIDTH-1:0] pend_addr;
  // A jump arriving in the same cycle as an advance is kept for the following advance,
  // since the advance already uses the previously registered target.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else if (except_start) begin
      pend_vld <= 1'b0;
    end else if (jump_valid) begin
      pend_vld  <= 1'b1;
      pend_addr <= jump_addr;
    end else if (advance) begin
      pend_vld <= 1'b0;
    end
  end
  assign next_pc = except_start ? except_vect : pend_vld ? pend_addr : pc + UPARC_ADDR_WIDTH'(4);
  assign pc_load = except_start | advance;
endmodule

// File: rtl/uparc_fetch.sv
// uparc_fetch: instruction fetch stage, owns the PC and the instruction bus read handshake
//   Build option UPARC_FETCH_ALIGN_CHECK_EN: when defined, a misaligned PC raises o_addr_error
//   instead of issuing a read; when undefined, the bus address low bits are forced to zero.
// Ports
//   clk, nrst                               : clock, asynchronous active-low reset
//   i_exec_stall, i_mem_stall, i_wait_stall : downstream stalls holding the current word
//   o_fetch_stall                           : 1 while no valid word is held for decode
//   i_jump_valid, i_jump_addr               : jump redirect, taken at the next advance
//   i_except_start, i_except_vect           : exception redirect, immediate
//   o_instr, o_pc                           : word presented to decode and its PC
//   o_bus_error, o_addr_error               : one-cycle fetch fault pulses
//   o_ibus_addr, o_ibus_rd                  : read request, held until i_ibus_rdc
//   i_ibus_rdc, i_ibus_data, i_ibus_err     : read completion, data and error
module uparc_fetch
  import uparc_fetch_pkg::*;
#(
  parameter logic [UPARC_ADDR_WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_exec_stall,
  input  logic                         i_mem_stall,
  input  logic                         i_wait_stall,
  output logic                         o_fetch_stall,
  input  logic                         i_jump_valid,
  input  logic [UPARC_ADDR_WIDTH-1:0]  i_jump_addr,
  input  logic                         i_except_start,
  input  logic [UPARC_ADDR_WIDTH-1:0]  i_except_vect,
  output logic [UPARC_INSTR_WIDTH-1:0] o_instr,
  output logic [UPARC_ADDR_WIDTH-1:0]  o_pc,
  output logic                         o_bus_error,
  output logic                         o_addr_error,
  output logic [UPARC_ADDR_WIDTH-1:0]  o_ibus_addr,
  output logic                         o_ibus_rd,
  input  logic                         i_ibus_rdc,
  input  logic [UPARC_INSTR_WIDTH-1:0] i_ibus_data,
  input  logic                         i_ibus_err
);
  fetch_state_t                state, state_d;
  logic [UPARC_ADDR_WIDTH-1:0] pc, next_pc, fetch_addr;
  logic                        pc_load, discard, misalign, other_stall;
  logic                        in_fetch, in_wait, in_hold;
  logic                        rd_done, take, issue, addr_fault, advance;
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
  assign misalign   = |pc[1:0];
  assign fetch_addr = pc;
`else
  assign misalign   = 1'b0;
  assign fetch_addr = {pc[UPARC_ADDR_WIDTH-1:2], 2'b00};
`endif
  assign other_stall   = i_exec_stall | i_mem_stall | i_wait_stall;
  assign in_fetch      = state == ST_FETCH;
  assign in_wait       = state == ST_WAIT;
  assign in_hold       = state == ST_HOLD;
  assign o_fetch_stall = ~in_hold;
  assign rd_done       = in_wait & i_ibus_rdc;
  // Completion data is dropped if an exception arrived while the read was in flight
  // or arrives in the completion cycle itself.
  assign take          = rd_done & ~discard & ~i_except_start;
  assign issue         = in_fetch & ~i_except_start & ~misalign;
  assign addr_fault    = in_fetch & ~i_except_start & misalign;
  assign advance       = in_hold & ~other_stall & ~i_except_start;
  uparc_fetch_pcsel u_pcsel (
    .clk          (clk),
    .nrst         (nrst),
    .pc           (pc),
    .jump_valid   (i_jump_valid),
    .jump_addr    (i_jump_addr),
    .except_start (i_except_start),
    .except_vect  (i_except_vect),
    .advance      (advance),
    .next_pc      (next_pc),
    .pc_load      (pc_load)
  );
  always_comb begin
    state_d = state;
    state_d = in_fetch ? (i_except_start ? ST_FETCH : misalign ? ST_HOLD : ST_WAIT) :
              in_wait  ? (!i_ibus_rdc ? ST_WAIT : take ? ST_HOLD : ST_FETCH) :
              in_hold  ? ((i_except_start | ~other_stall) ? ST_FETCH : ST_HOLD) :
                         ST_FETCH;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_FETCH;
    else state <= state_d;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc           <= RESET_PC;
      o_pc         <= RESET_PC;
      o_instr      <= UPARC_NOP;
      o_ibus_rd    <= 1'b0;
      o_ibus_addr  <= '0;
      o_bus_error  <= 1'b0;
      o_addr_error <= 1'b0;
      discard      <= 1'b0;
    end else begin
      if (pc_load) pc <= next_pc;
      o_bus_error  <= take & i_ibus_err;
      o_addr_error <= addr_fault;
      discard      <= in_wait & ~i_ibus_rdc & (discard | i_except_start);
      if (issue) begin
        o_ibus_rd   <= 1'b1;
        o_ibus_addr <= fetch_addr;
      end else if (rd_done) begin
        o_ibus_rd <= 1'b0;
      end
      if (take) begin
        o_instr <= i_ibus_err ? UPARC_NOP : i_ibus_data;
        o_pc    <= pc;
      end else if (addr_fault) begin
        o_instr <= UPARC_NOP;
        o_pc    <= pc;
      end else if (i_except_start & ~in_wait) begin
        o_instr <= UPARC_NOP;
      end
    end
  end
endmodule

// File: tb/tb_uparc_fetch.sv
// tb_uparc_fetch: randomized bench for uparc_fetch against a transaction-level model
//   The model tracks only the architectural fetch stream: the address decode should see next,
//   the pending jump target and the fault pulses owed for the current word.
module tb_uparc_fetch;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  logic        clk = 1'b0, nrst;
  logic        i_exec_stall, i_mem_stall, i_wait_stall, o_fetch_stall;
  logic        i_jump_valid, i_except_start;
  logic [31:0] i_jump_addr, i_except_vect, o_instr, o_pc, o_ibus_addr, i_ibus_data;
  logic        o_bus_error, o_addr_error, o_ibus_rd, i_ibus_rdc, i_ibus_err;
  int errors = 0, checks = 0;
  logic [31:0] exp_pc, pend, prev_addr, last_data;
  bit          pend_v, busy, last_err, nop_chk, rnd_en;
  int          berr_n, aerr_n, req_n, use_n, idle, dly, cnt;
  always #5 clk = ~clk;
  uparc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .nrst(nrst),
    .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall), .i_wait_stall(i_wait_stall),
    .o_fetch_stall(o_fetch_stall),
    .i_jump_valid(i_jump_valid), .i_jump_addr(i_jump_addr),
    .i_except_start(i_except_start), .i_except_vect(i_except_vect),
    .o_instr(o_instr), .o_pc(o_pc), .o_bus_error(o_bus_error), .o_addr_error(o_addr_error),
    .o_ibus_addr(o_ibus_addr), .o_ibus_rd(o_ibus_rd),
    .i_ibus_rdc(i_ibus_rdc), .i_ibus_data(i_ibus_data), .i_ibus_err(i_ibus_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Inputs for the coming cycle, applied just after the rising edge; the bus answers a
  // request after dly idle cycles (dly=0 means rdc in the first cycle rd is seen).
  task automatic drive();
    i_jump_valid   = rnd_en && $urandom_range(29) == 0;
    i_jump_addr    = $urandom & ($urandom_range(7) == 0 ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
    i_except_start = rnd_en && $urandom_range(49) == 0;
    i_except_vect  = $urandom_range(1) == 1 ? 32'h8000_0180 : ($urandom & 32'hFFFF_FFFC);
    i_exec_stall   = rnd_en && $urandom_range(7) == 0;
    i_mem_stall    = rnd_en && $urandom_range(7) == 0;
    i_wait_stall   = rnd_en && $urandom_range(9) == 0;
    if (o_ibus_rd && cnt >= dly) begin
      i_ibus_rdc  = 1'b1;
      i_ibus_data = $urandom;
      i_ibus_err  = rnd_en && $urandom_range(7) == 0;
      last_data   = i_ibus_data;
      last_err    = i_ibus_err;
      cnt         = 0;
      dly         = rnd_en ? int'($urandom_range(5)) : 0;
    end else begin
      i_ibus_rdc = 1'b0;
      i_ibus_err = 1'b0;
      cnt        = o_ibus_rd ? cnt + 1 : 0;
    end
  endtask
  // Observation point mid-cycle: outputs reflect the current state, inputs are what the
  // next rising edge will sample.
  task automatic observe();
    logic [31:0] ei;
    int          eb, ea;
    bit          other;
    other = i_exec_stall | i_mem_stall | i_wait_stall;
    if (o_ibus_rd && busy) check("addr_stable", o_ibus_addr, prev_addr);
    if (o_ibus_rd && !busy) begin
      req_n++;
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
      check("req_addr", o_ibus_addr, exp_pc);
      check("req_aligned", {30'd0, o_ibus_addr[1:0]}, 32'd0);
`else
      check("req_addr", o_ibus_addr, {exp_pc[31:2], 2'b00});
`endif
    end
    busy      = o_ibus_rd && !i_ibus_rdc;
    prev_addr = o_ibus_addr;
    if (nop_chk) check("except_nop", o_instr, 32'd0);
    nop_chk = 1'b0;
    if (o_bus_error) berr_n++;
    if (o_addr_error) aerr_n++;
    idle++;
    if (i_except_start) begin
      nop_chk = !o_fetch_stall;
      exp_pc  = i_except_vect;
      pend_v  = 1'b0;
      berr_n  = 0;
      aerr_n  = 0;
    end else begin
      if (!o_fetch_stall && !other) begin
        use_n++;
        idle = 0;
        ei = last_err ? 32'd0 : last_data;
        eb = int'(last_err);
        ea = 0;
`ifdef UPARC_FETCH_ALIGN_CHECK_EN
        if (exp_pc[1:0] != 2'b00) begin
          ei = 32'd0;
          eb = 0;
          ea = 1;
        end
`endif
        check("o_pc", o_pc, exp_pc);
        check("o_instr", o_instr, ei);
        check("bus_err_pulses", berr_n, eb);
        check("addr_err_pulses", aerr_n, ea);
        exp_pc = pend_v ? pend : exp_pc + 32'd4;
        pend_v = 1'b0;
        berr_n = 0;
        aerr_n = 0;
      end
      if (i_jump_valid) begin
        pend   = i_jump_addr;
        pend_v = 1'b1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    observe();
  endtask
  initial begin
    nrst = 1'b0;
    rnd_en = 1'b0;
    {i_exec_stall, i_mem_stall, i_wait_stall, i_jump_valid, i_except_start, i_ibus_rdc, i_ibus_err} = '0;
    {i_jump_addr, i_except_vect, i_ibus_data, last_data} = '0;
    {pend_v, busy, last_err, nop_chk} = '0;
    {berr_n, aerr_n, req_n, use_n, idle, dly, cnt} = '0;
    exp_pc = RESET_PC;
    pend = '0;
    prev_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_pc", o_pc, RESET_PC);
    check("rst_o_instr", o_instr, 32'd0);
    check("rst_fetch_stall", o_fetch_stall, 1);
    check("rst_rd", o_ibus_rd, 0);
    check("rst_bus_error", o_bus_error, 0);
    check("rst_addr_error", o_addr_error, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (12) step();
    check("zero_wait_reqs", req_n, 4);
    check("zero_wait_words", use_n, 4);
    rnd_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (idle > 400) begin
        check("progress", idle, 0);
        break;
      end
    end
    rnd_en = 1'b0;
    for (int c = 0; c < 60 && !o_ibus_rd; c++) step();
    check("rd_before_reset", o_ibus_rd, 1);
    nrst = 1'b0;
    #1;
    check("async_rst_rd", o_ibus_rd, 0);
    check("async_rst_stall", o_fetch_stall, 1);
    check("async_rst_pc", o_pc, RESET_PC);
    check("async_rst_instr", o_instr, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
